// File: rtl/logic_clock_domain_crossing_arbiter.sv
// Packet-aware round-robin arbiter feeding one CDC FIFO Rx port.
// Ports: aclk/reset; rx_t* per requester in; tx_t* shared out with tx_tid.
module logic_clock_domain_crossing_arbiter #(
  parameter int INPUTS   = 4,
  parameter int WIDTH    = 8,
  parameter int ID_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic [INPUTS-1:0]              rx_tvalid,
  input  logic [INPUTS-1:0]              rx_tlast,
  input  logic [INPUTS-1:0][WIDTH-1:0]   rx_tdata,
  output logic [INPUTS-1:0]              rx_tready,
  input  logic                           tx_tready,
  output logic                           tx_tvalid,
  output logic                           tx_tlast,
  output logic [WIDTH-1:0]               tx_tdata,
  output logic [ID_WIDTH-1:0]            tx_tid
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(INPUTS - 1);

  state_t              state, state_d;
  logic [ID_WIDTH-1:0] grant, grant_d;
  logic [ID_WIDTH-1:0] ptr, ptr_d;
  logic [ID_WIDTH-1:0] pick;
  logic                found;
  logic                can_load;
  logic                accept;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(
    input logic [ID_WIDTH-1:0] v
  );
    return (v == LAST_ID) ? '0 : v + ID_WIDTH'(1);
  endfunction

  // Cyclic search starting at ptr; first valid requester wins.
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < INPUTS; i++) begin
      if (!found && rx_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  // Output register can take a beat when empty or draining this cycle.
  assign can_load = !tx_tvalid || tx_tready;
  assign accept   = (state == LOCKED) && rx_tvalid[grant] && can_load;

  always_comb begin
    rx_tready = '0;
    if (state == LOCKED) begin
      rx_tready[grant] = can_load;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    ptr_d   = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          grant_d = pick;
        end
      end
      LOCKED: begin
        if (accept && rx_tlast[grant]) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(grant);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      ptr   <= ptr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_tdata  <= '0;
      tx_tid    <= '0;
    end else if (accept) begin
      tx_tvalid <= 1'b1;
      tx_tlast  <= rx_tlast[grant];
      tx_tdata  <= rx_tdata[grant];
      tx_tid    <= grant;
    end else if (tx_tready) begin
      tx_tvalid <= 1'b0;
    end
  end

endmodule
